// File: rtl/recip_result_reader.sv
// Consumer end of the TDC result handshake: latches one coarse/fine result, acknowledges it,
// and streams it out as a framed byte sequence SYNC, coarse (MSB first), fine, checksum.
module recip_result_reader #(
   parameter int unsigned COARSE_WIDTH    = 24,
   parameter int unsigned FINE_WIDTH      = 8,
   parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
   parameter int unsigned FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk_fast,
   input  logic                       rst_n,
   input  logic                       tdc_valid_fast,
   output logic                       tdc_ack_fast,
   input  logic [COARSE_WIDTH-1:0]    tdc_coarse_fast,
   input  logic [FINE_WIDTH-1:0]      tdc_fine_raw_fast,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

   localparam int unsigned NB    = (COARSE_WIDTH + 7) / 8;
   localparam int unsigned CW    = 8 * NB;
   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 2);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [CW-1:0]              coarse_q, coarse_d;
   logic [7:0]                 fine_q, fine_d;
   logic [7:0]                 chk_q, chk_d;
   logic                       ack_q, ack_d;
   logic [7:0]                 tx_data_q, tx_data_d;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [CW-1:0]              coarse_in;
   logic [7:0]                 fine_in;

   function automatic logic [7:0] frame_chk(input logic [CW-1:0] c, input logic [7:0] f);
      logic [7:0] s;
      s = f;
      for (int i = 0; i < int'(NB); i++) s = s + c[8*i +: 8];
      return s;
   endfunction

   // Byte index 0 is SYNC, 1..NB the coarse bytes MSB first, NB+1 fine, NB+2 checksum.
   function automatic logic [7:0] byte_sel(input logic [IDX_W-1:0] idx, input logic [CW-1:0] c,
                                           input logic [7:0] f, input logic [7:0] chk);
      int k;
      logic [7:0] r;
      k = int'(idx);
      if (k == 0)                 r = SYNC_BYTE;
      else if (k <= int'(NB))     r = c[8*(int'(NB)-k) +: 8];
      else if (k == int'(NB) + 1) r = f;
      else                        r = chk;
      return r;
   endfunction

   assign coarse_in = CW'(tdc_coarse_fast);
   assign fine_in   = 8'(tdc_fine_raw_fast);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      coarse_d      = coarse_q;
      fine_d        = fine_q;
      chk_d         = chk_q;
      ack_d         = 1'b0;
      tx_data_d     = tx_data_q;
      frame_count_d = frame_count_q;
      case (state_q)
         S_IDLE: begin
            // The !ack term keeps a producer's stale valid from being taken twice.
            if (tdc_valid_fast && !ack_q) begin
               coarse_d  = coarse_in;
               fine_d    = fine_in;
               chk_d     = frame_chk(coarse_in, fine_in);
               ack_d     = 1'b1;
               tx_data_d = SYNC_BYTE;
               idx_d     = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d       = S_IDLE;
                  tx_data_d     = 8'h00;
                  frame_count_d = frame_count_q + 1'b1;
               end else begin
                  idx_d     = idx_q + 1'b1;
                  tx_data_d = byte_sel(idx_q + 1'b1, coarse_q, fine_q, chk_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         coarse_q      <= '0;
         fine_q        <= '0;
         chk_q         <= '0;
         ack_q         <= 1'b0;
         tx_data_q     <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         coarse_q      <= coarse_d;
         fine_q        <= fine_d;
         chk_q         <= chk_d;
         ack_q         <= ack_d;
         tx_data_q     <= tx_data_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign tdc_ack_fast = ack_q;
   assign tx_data      = tx_data_q;
   assign tx_valid     = (state_q == S_SEND);
   assign busy         = (state_q == S_SEND);
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_recip_result_reader.sv
// Bench for recip_result_reader: a default-width instance and a narrow instance
// (12-bit coarse, 4-bit fine, 4-bit frame counter) checked against a byte-queue scoreboard.
module tb_recip_result_reader;

   logic clk_fast = 1'b0;
   always #5 clk_fast = ~clk_fast;

   logic        rst_n;
   logic        a_valid, a_ack, a_rdy, a_txv, a_busy;
   logic [23:0] a_coarse;
   logic [7:0]  a_fine, a_data;
   logic [15:0] a_fc;
   logic        b_valid, b_ack, b_rdy, b_txv, b_busy;
   logic [11:0] b_coarse;
   logic [3:0]  b_fine, b_fc;
   logic [7:0]  b_data;

   recip_result_reader dut_a (
      .clk_fast(clk_fast), .rst_n(rst_n), .tdc_valid_fast(a_valid), .tdc_ack_fast(a_ack),
      .tdc_coarse_fast(a_coarse), .tdc_fine_raw_fast(a_fine), .tx_data(a_data),
      .tx_valid(a_txv), .tx_ready(a_rdy), .busy(a_busy), .frame_count(a_fc));

   recip_result_reader #(.COARSE_WIDTH(12), .FINE_WIDTH(4), .FRAME_CNT_WIDTH(4)) dut_b (
      .clk_fast(clk_fast), .rst_n(rst_n), .tdc_valid_fast(b_valid), .tdc_ack_fast(b_ack),
      .tdc_coarse_fast(b_coarse), .tdc_fine_raw_fast(b_fine), .tx_data(b_data),
      .tx_valid(b_txv), .tx_ready(b_rdy), .busy(b_busy), .frame_count(b_fc));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] a_exp[$], a_obs[$], b_exp[$], b_obs[$];
   int a_obs_cyc[$];

   always @(posedge clk_fast) cyc <= cyc + 1;

   // Transfers are captured mid-cycle; the transfer itself completes at the next rising edge.
   always @(negedge clk_fast) begin
      if (a_txv && a_rdy) begin a_obs.push_back(a_data); a_obs_cyc.push_back(cyc); end
      if (b_txv && b_rdy) b_obs.push_back(b_data);
   end

   task automatic step();
      @(posedge clk_fast);
      #1;
   endtask

   task automatic model_frame(input logic [31:0] c, input logic [7:0] f, input int nb, input bit to_b);
      logic [7:0] q[$];
      logic [7:0] s;
      s = 8'h00;
      q.push_back(8'hA5);
      for (int i = nb - 1; i >= 0; i--) begin q.push_back(c[8*i +: 8]); s = s + c[8*i +: 8]; end
      q.push_back(f);
      s = s + f;
      q.push_back(s);
      foreach (q[i]) if (to_b) b_exp.push_back(q[i]); else a_exp.push_back(q[i]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; a_valid = 0; a_rdy = 0; a_coarse = '0; a_fine = '0;
      b_valid = 0; b_rdy = 0; b_coarse = '0; b_fine = '0;
      step(); step();
      checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h want 0", a_ack); end
      checks++; if (a_txv !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0h want 0", a_txv); end
      checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h want 0", a_data); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", a_busy); end
      checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", a_fc); end
      checks++; if (b_txv !== 1'b0 || b_fc !== 4'd0) begin errors++; $display("FAIL reset_b got txv=%0h fc=%0d want 0 0", b_txv, b_fc); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_frame();
      int n;
      a_exp.delete(); a_obs.delete(); a_obs_cyc.delete();
      model_frame(32'h00C350, 8'h12, 3, 0);
      a_coarse = 24'h00C350; a_fine = 8'h12; a_rdy = 1; a_valid = 1;
      step();
      checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %0h want 1", a_ack); end
      checks++; if (a_txv !== 1'b1 || a_data !== 8'hA5) begin errors++; $display("FAIL single_first got v=%0h d=%0h want 1 a5", a_txv, a_data); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h want 1", a_busy); end
      a_valid = 0; a_coarse = 24'h123456; a_fine = 8'h99;
      step();
      checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %0h want 0", a_ack); end
      n = 0;
      while (a_busy && n < 20) begin step(); n++; end
      checks++; if (n >= 20) begin errors++; $display("FAIL single_timeout got busy=%0h want 0", a_busy); end
      checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL single_len got %0d want %0d", a_obs.size(), a_exp.size()); end
      for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
         checks++; if (a_obs[i] !== a_exp[i]) begin errors++; $display("FAIL single_byte%0d got %0h want %0h", i, a_obs[i], a_exp[i]); end
      end
      for (int i = 1; i < a_obs_cyc.size(); i++) begin
         checks++; if (a_obs_cyc[i] - a_obs_cyc[i-1] != 1) begin errors++; $display("FAIL single_gap%0d got %0d want 1", i, a_obs_cyc[i] - a_obs_cyc[i-1]); end
      end
      checks++; if (a_fc !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_fc); end
      checks++; if (a_txv !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %0h want 0", a_txv); end
   endtask

   task automatic test_backpressure();
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int n;
      bit stall;
      logic [7:0] pd;
      a_exp.delete(); a_obs.delete(); a_obs_cyc.delete();
      model_frame(32'h00C350, 8'h12, 3, 0);
      a_coarse = 24'h00C350; a_fine = 8'h12; a_rdy = 1; a_valid = 1;
      step();
      a_valid = 0; a_coarse = 24'hDEAD00; a_fine = 8'h00;
      n = 1;
      while (a_busy && n < 60) begin
         a_rdy = pat[n % 4];
         stall = a_txv && !a_rdy;
         pd = a_data;
         step();
         if (stall) begin
            checks++; if (a_txv !== 1'b1 || a_data !== pd) begin errors++; $display("FAIL bp_hold got v=%0h d=%0h want 1 %0h", a_txv, a_data, pd); end
         end
         n++;
      end
      a_rdy = 1;
      checks++; if (n >= 60) begin errors++; $display("FAIL bp_timeout got busy=%0h want 0", a_busy); end
      checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", a_obs.size(), a_exp.size()); end
      for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
         checks++; if (a_obs[i] !== a_exp[i]) begin errors++; $display("FAIL bp_byte%0d got %0h want %0h", i, a_obs[i], a_exp[i]); end
      end
      checks++; if (a_fc !== 16'd2) begin errors++; $display("FAIL bp_count got %0d want 2", a_fc); end
   endtask

   task automatic test_back_to_back();
      int n_ack, ack1;
      bit prev_ack;
      a_exp.delete(); a_obs.delete(); a_obs_cyc.delete();
      model_frame(32'h00C350, 8'h12, 3, 0);
      model_frame(32'hFFFFFF, 8'hFF, 3, 0);
      a_coarse = 24'h00C350; a_fine = 8'h12; a_rdy = 1; a_valid = 1;
      n_ack = 0; ack1 = -100; prev_ack = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (a_ack) begin
            checks++; if (prev_ack) begin errors++; $display("FAIL b2b_ack_width got 2 cycles want 1"); end
            n_ack++;
            if (n_ack == 1) ack1 = i; else a_valid = 0;
         end
         if (n_ack == 1 && i == ack1 + 2) a_valid = 0;
         if (n_ack == 1 && i == ack1 + 4) begin a_valid = 1; a_coarse = 24'hFFFFFF; a_fine = 8'hFF; end
         prev_ack = a_ack;
         if (n_ack >= 2 && !a_busy) break;
      end
      a_valid = 0;
      checks++; if (n_ack != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", n_ack); end
      checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", a_obs.size(), a_exp.size()); end
      for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
         checks++; if (a_obs[i] !== a_exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %0h want %0h", i, a_obs[i], a_exp[i]); end
      end
      if (a_obs_cyc.size() == 12) begin
         checks++; if (a_obs_cyc[6] - a_obs_cyc[5] != 2) begin errors++; $display("FAIL b2b_period got %0d want 2", a_obs_cyc[6] - a_obs_cyc[5]); end
      end
      checks++; if (a_fc !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", a_fc); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      a_coarse = 24'h111111; a_fine = 8'h22; a_rdy = 1; a_valid = 1;
      step();
      a_valid = 0;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_txv !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_valid_busy got %0h %0h want 0 0", a_txv, a_busy); end
      checks++; if (a_ack !== 1'b0 || a_data !== 8'h00) begin errors++; $display("FAIL rstmid_ack_data got %0h %0h want 0 0", a_ack, a_data); end
      checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", a_fc); end
      step(); step();
      rst_n = 1'b1;
      step();
      a_exp.delete(); a_obs.delete(); a_obs_cyc.delete();
      model_frame(32'h0A0B0C, 8'h0D, 3, 0);
      a_coarse = 24'h0A0B0C; a_fine = 8'h0D; a_valid = 1;
      step();
      a_valid = 0;
      n = 0;
      while (a_busy && n < 20) begin step(); n++; end
      checks++; if (n >= 20) begin errors++; $display("FAIL rstmid_timeout got busy=%0h want 0", a_busy); end
      checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL rstmid_len got %0d want %0d", a_obs.size(), a_exp.size()); end
      for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
         checks++; if (a_obs[i] !== a_exp[i]) begin errors++; $display("FAIL rstmid_byte%0d got %0h want %0h", i, a_obs[i], a_exp[i]); end
      end
      checks++; if (a_fc !== 16'd1) begin errors++; $display("FAIL rstmid_count_after got %0d want 1", a_fc); end
   endtask

   task automatic test_width_corner();
      int n;
      b_exp.delete(); b_obs.delete();
      model_frame(32'h00000ABC, 8'h07, 2, 1);
      b_coarse = 12'hABC; b_fine = 4'h7; b_rdy = 1; b_valid = 1;
      step();
      checks++; if (b_ack !== 1'b1 || b_data !== 8'hA5) begin errors++; $display("FAIL width_first got ack=%0h d=%0h want 1 a5", b_ack, b_data); end
      b_valid = 0;
      n = 0;
      while (b_busy && n < 20) begin step(); n++; end
      checks++; if (n >= 20) begin errors++; $display("FAIL width_timeout got busy=%0h want 0", b_busy); end
      checks++; if (b_obs.size() != b_exp.size()) begin errors++; $display("FAIL width_len got %0d want %0d", b_obs.size(), b_exp.size()); end
      for (int i = 0; i < b_obs.size() && i < b_exp.size(); i++) begin
         checks++; if (b_obs[i] !== b_exp[i]) begin errors++; $display("FAIL width_byte%0d got %0h want %0h", i, b_obs[i], b_exp[i]); end
      end
      checks++; if (b_fc !== 4'd1) begin errors++; $display("FAIL width_count got %0d want 1", b_fc); end
   endtask

   task automatic test_counter_wrap();
      int n;
      logic [3:0] want;
      for (int f = 2; f <= 17; f++) begin
         b_coarse = 12'(f * 37); b_fine = 4'(f); b_rdy = 1; b_valid = 1;
         step();
         b_valid = 0;
         n = 0;
         while (b_busy && n < 20) begin step(); n++; end
         if (n >= 20) begin checks++; errors++; $display("FAIL wrap_timeout frame %0d got busy=1 want 0", f); end
         if (f >= 15) begin
            want = 4'(f % 16);
            checks++; if (b_fc !== want) begin errors++; $display("FAIL wrap_count%0d got %0d want %0d", f, b_fc, want); end
         end
      end
      checks++; if (b_obs.size() != 17 * 5) begin errors++; $display("FAIL wrap_bytes got %0d want %0d", b_obs.size(), 17 * 5); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_width_corner();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
